// File: rtl/constraint_sample_sequencer_if.sv
// rtl/constraint_sample_sequencer_if.sv - satisfying-sample output stream
interface constraint_sample_sequencer_if #(
  parameter int VEC_W = 96
);
  logic             sample_valid;
  logic             sample_ready;
  logic [VEC_W-1:0] sample_data;

  modport master (output sample_valid, output sample_data, input sample_ready);
  modport slave  (input sample_valid, input sample_data, output sample_ready);
endinterface

// File: rtl/constraint_sample_sequencer.sv
// rtl/constraint_sample_sequencer.sv - LFSR candidate generator and sampler for a constraint checker
module constraint_sample_sequencer #(
  parameter int          VEC_W     = 96,
  parameter int          CHK_LAT   = 0,
  parameter int          MAX_TRIES = 1024,
  parameter logic [31:0] SEED      = 32'hACE1_2024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [15:0]                   num_req,
  input  logic                          abort,
  input  logic                          seed_load,
  input  logic [31:0]                   seed_in,
  output logic [VEC_W-1:0]              cand,
  input  logic                          chk_sat,
  constraint_sample_sequencer_if.master smp,
  output logic                          busy,
  output logic                          done,
  output logic                          fail,
  output logic [15:0]                   try_cnt,
  output logic [15:0]                   acc_cnt
);
  localparam int          NCHUNK = (VEC_W + 31) / 32;
  localparam int          FCW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int          WCW    = (CHK_LAT > 0) ? $clog2(CHK_LAT + 1) : 1;
  localparam logic [31:0] MASK   = 32'h8020_0003;
  localparam logic [15:0] MAX_T  = 16'(MAX_TRIES);

  typedef enum logic [2:0] {IDLE, FILL, WAIT, EVAL, HOLD} state_t;

  state_t           state, state_d;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_nx;
  logic [VEC_W-1:0] cand_fill;
  logic [FCW-1:0]   fcnt;
  logic [WCW-1:0]   wcnt;
  logic [15:0]      num_req_q;
  logic [15:0]      try_inc;
  logic [15:0]      acc_inc;
  logic             fill_last;
  logic             handshake;

  assign lfsr_nx   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? MASK : 32'h0);
  assign fill_last = (fcnt == FCW'(NCHUNK - 1));
  assign handshake = (state == HOLD) && smp.sample_ready;
  // counters stick at all-ones instead of wrapping
  assign try_inc   = (try_cnt == 16'hFFFF) ? try_cnt : try_cnt + 16'd1;
  assign acc_inc   = (acc_cnt == 16'hFFFF) ? acc_cnt : acc_cnt + 16'd1;

  // each fill cycle shifts the freshly stepped LFSR word into the low end
  generate
    if (VEC_W > 32) begin : g_wide
      assign cand_fill = {cand[VEC_W-33:0], lfsr_nx};
    end else begin : g_narrow
      assign cand_fill = lfsr_nx[VEC_W-1:0];
    end
  endgenerate

  assign busy             = (state != IDLE);
  assign smp.sample_valid = (state == HOLD);
  assign smp.sample_data  = cand;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // next-state decode; abort overrides everything
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (start) state_d = (num_req == 16'd0) ? IDLE : FILL;
      FILL: if (fill_last) state_d = (CHK_LAT == 0) ? EVAL : WAIT;
      WAIT: if (wcnt == WCW'(1)) state_d = EVAL;
      EVAL: begin
        if (chk_sat)               state_d = HOLD;
        else if (try_inc == MAX_T) state_d = IDLE;
        else                       state_d = FILL;
      end
      HOLD: if (smp.sample_ready) state_d = (acc_inc == num_req_q) ? IDLE : FILL;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // datapath: LFSR, candidate, counters and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= SEED;
      cand      <= '0;
      fcnt      <= '0;
      wcnt      <= '0;
      num_req_q <= 16'd0;
      try_cnt   <= 16'd0;
      acc_cnt   <= 16'd0;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      unique case (state)
        IDLE: if (!abort) begin
          // the seed lands before FILL starts, so a same-cycle start uses it
          if (seed_load) lfsr <= (seed_in == 32'h0) ? 32'h1 : seed_in;
          if (start) begin
            num_req_q <= num_req;
            try_cnt   <= 16'd0;
            acc_cnt   <= 16'd0;
            fcnt      <= '0;
            if (num_req == 16'd0) done <= 1'b1;
          end
        end
        FILL: begin
          lfsr <= lfsr_nx;
          cand <= cand_fill;
          fcnt <= fill_last ? '0 : fcnt + FCW'(1);
          wcnt <= WCW'(CHK_LAT);
        end
        WAIT: wcnt <= wcnt - WCW'(1);
        EVAL: if (!chk_sat) begin
          try_cnt <= try_inc;
          if (try_inc == MAX_T && !abort) fail <= 1'b1;
        end
        HOLD: if (handshake) begin
          // an accepted sample counts even when abort lands on the same cycle
          acc_cnt <= acc_inc;
          try_cnt <= 16'd0;
          if (acc_inc == num_req_q && !abort) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
